// File: rtl/basys3_input_capture_if.sv
// rtl/basys3_input_capture_if.sv - captured-byte handshake between the input front end and the CPU
//
// Signals:
//   data_out   captured switch byte
//   data_valid data_out holds a byte the CPU has not consumed
//   data_ack   CPU consumes the byte
//   overrun    sticky flag: a capture press arrived while a byte was pending
// Modports: master = input front end, slave = CPU side.
interface basys3_input_capture_if;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ack;
  logic       overrun;

  modport master (
    output data_out,
    output data_valid,
    output overrun,
    input  data_ack
  );

  modport slave (
    input  data_out,
    input  data_valid,
    input  overrun,
    output data_ack
  );
endinterface

// File: rtl/basys3_input_capture.sv
// rtl/basys3_input_capture.sv - synchronise, debounce and capture Basys3 buttons and switches
//
// Ports:
//   clk, rst        board clock, asynchronous active-high reset
//   sw              raw slide switches
//   btnC..btnL      raw push buttons
//   buttons_stable  debounced buttons {C,U,R,D,L}
//   press_pulse     one-cycle pulse after a debounced button rises, same order
//   sw_stable       debounced switches
//   cap             captured-byte handshake (master side)
// btnC captures sw_stable[7:0], btnU captures sw_stable[15:8].
module basys3_input_capture #(
  parameter int SAMPLE_DIV     = 65536,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [15:0]                   sw,
  input  logic                          btnC,
  input  logic                          btnU,
  input  logic                          btnR,
  input  logic                          btnD,
  input  logic                          btnL,
  output logic [4:0]                    buttons_stable,
  output logic [4:0]                    press_pulse,
  output logic [15:0]                   sw_stable,
  basys3_input_capture_if.master        cap
);

  localparam int NCH = 21;
  localparam int TW  = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CW  = (STABLE_SAMPLES > 1) ? $clog2(STABLE_SAMPLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_SAMPLES - 1);

  // Channel order: bits 20:5 switches, bits 4:0 buttons {C,U,R,D,L}.
  logic [NCH-1:0] raw;
  logic [NCH-1:0] sync1;
  logic [NCH-1:0] sync2;
  logic [NCH-1:0] stable;
  logic [CW-1:0]  ch_cnt [NCH];
  logic [TW-1:0]  tick_cnt;
  logic           tick;
  logic [4:0]     btn_prev;

  assign raw            = {sw, btnC, btnU, btnR, btnD, btnL};
  assign buttons_stable = stable[4:0];
  assign sw_stable      = stable[20:5];
  assign tick           = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // A channel accepts a new level only after STABLE_SAMPLES consecutive ticks
  // disagree with the current stable value; any agreeing tick restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= '0;
      for (int i = 0; i < NCH; i++) ch_cnt[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < NCH; i++) begin
        if (sync2[i] == stable[i]) begin
          ch_cnt[i] <= '0;
        end else if (ch_cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          ch_cnt[i] <= '0;
        end else begin
          ch_cnt[i] <= ch_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_prev    <= '0;
      press_pulse <= '0;
    end else begin
      btn_prev    <= buttons_stable;
      press_pulse <= buttons_stable & ~btn_prev;
    end
  end

  typedef enum logic {IDLE, HOLD} state_t;
  state_t state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cap.data_out   <= '0;
      cap.data_valid <= 1'b0;
      cap.overrun    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // C has priority; a coincident U press is silently dropped.
          if (press_pulse[4]) begin
            cap.data_out   <= sw_stable[7:0];
            cap.data_valid <= 1'b1;
            state          <= HOLD;
          end else if (press_pulse[3]) begin
            cap.data_out   <= sw_stable[15:8];
            cap.data_valid <= 1'b1;
            state          <= HOLD;
          end
        end
        HOLD: begin
          if (press_pulse[4] || press_pulse[3]) cap.overrun <= 1'b1;
          if (cap.data_ack) begin
            cap.data_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_basys3_input_capture.sv
// tb/tb_basys3_input_capture.sv - directed self-checking bench for basys3_input_capture
module tb_basys3_input_capture;

  logic        clk;
  logic        rst;
  logic [15:0] sw;
  logic [4:0]  btn;
  logic [4:0]  buttons_stable;
  logic [4:0]  press_pulse;
  logic [15:0] sw_stable;
  int          errors;
  int          checks;

  basys3_input_capture_if cap_if ();

  basys3_input_capture #(
    .SAMPLE_DIV     (4),
    .STABLE_SAMPLES (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sw             (sw),
    .btnC           (btn[4]),
    .btnU           (btn[3]),
    .btnR           (btn[2]),
    .btnD           (btn[1]),
    .btnL           (btn[0]),
    .buttons_stable (buttons_stable),
    .press_pulse    (press_pulse),
    .sw_stable      (sw_stable),
    .cap            (cap_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] sw;
    logic [2:0]  btn;
    logic [15:0] exp_sw;
    logic [2:0]  exp_btn;
    int          exp_pulses;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_pulse(input int idx, input string name);
    int n;
    n = 0;
    while (press_pulse[idx] !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check(name, 32'(press_pulse[idx]), 32'd1);
  endtask

  task automatic ack_byte(input string name);
    cap_if.data_ack = 1'b1;
    step();
    cap_if.data_ack = 1'b0;
    check(name, 32'(cap_if.data_valid), 32'd0);
  endtask

  logic [31:0] acc;
  logic [15:0] prev_sw;
  logic [2:0]  prev_btn;
  int          pulses;
  logic [7:0]  held_out;
  logic        changed;

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    sw = '0;
    btn = '0;
    cap_if.data_ack = 1'b0;

    vecs[0] = '{16'hA5C3, 3'b000, 16'hA5C3, 3'b000, 0};
    vecs[1] = '{16'hA5C3, 3'b101, 16'hA5C3, 3'b101, 2};
    vecs[2] = '{16'h0000, 3'b111, 16'h0000, 3'b111, 1};
    vecs[3] = '{16'hFFFF, 3'b010, 16'hFFFF, 3'b010, 0};
    vecs[4] = '{16'h1234, 3'b011, 16'h1234, 3'b011, 1};
    vecs[5] = '{16'h0000, 3'b000, 16'h0000, 3'b000, 0};

    // Reset held with inputs toggling: every output must stay 0.
    acc = '0;
    for (int i = 0; i < 12; i++) begin
      sw = 16'($urandom);
      btn = 5'($urandom);
      cap_if.data_ack = 1'($urandom);
      step();
      acc = acc | {11'd0, buttons_stable, press_pulse, cap_if.data_valid, cap_if.overrun}
                | {16'd0, sw_stable} | {24'd0, cap_if.data_out};
    end
    check("reset_outputs", acc, 32'd0);
    sw = '0;
    btn = '0;
    cap_if.data_ack = 1'b0;
    step();
    rst = 1'b0;
    acc = '0;
    for (int i = 0; i < 100; i++) begin
      step();
      acc = acc | {25'd0, press_pulse, cap_if.data_valid, cap_if.overrun};
    end
    check("post_reset_quiet", acc, 32'd0);

    // Table: levels on switches and R/D/L buttons; latency window 11..14 cycles.
    prev_sw = '0;
    prev_btn = '0;
    for (int v = 0; v < 6; v++) begin
      sw = vecs[v].sw;
      btn = {2'b00, vecs[v].btn};
      pulses = 0;
      for (int c = 1; c <= 20; c++) begin
        step();
        for (int b = 0; b < 5; b++) pulses += int'(press_pulse[b]);
        if (c == 10) begin
          check($sformatf("vec%0d_sw_hold", v), 32'(sw_stable), 32'(prev_sw));
          check($sformatf("vec%0d_btn_hold", v), 32'(buttons_stable), 32'({2'b00, prev_btn}));
        end
        if (c == 16) begin
          check($sformatf("vec%0d_sw_new", v), 32'(sw_stable), 32'(vecs[v].exp_sw));
          check($sformatf("vec%0d_btn_new", v), 32'(buttons_stable), 32'({2'b00, vecs[v].exp_btn}));
        end
      end
      check($sformatf("vec%0d_sw_const", v), 32'(sw_stable), 32'(vecs[v].exp_sw));
      check($sformatf("vec%0d_pulses", v), 32'(pulses), 32'(vecs[v].exp_pulses));
      check($sformatf("vec%0d_no_capture", v), 32'(cap_if.data_valid), 32'd0);
      prev_sw = vecs[v].exp_sw;
      prev_btn = vecs[v].exp_btn;
    end

    // Bounce: btnL period-6 square wave never gives 3 consecutive high samples.
    acc = '0;
    for (int i = 0; i < 40; i++) begin
      btn[0] = ((i / 3) % 2 == 0);
      step();
      acc = acc | {30'd0, buttons_stable[0], press_pulse[0]};
    end
    btn[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      acc = acc | {30'd0, buttons_stable[0], press_pulse[0]};
    end
    check("bounce_rejected", acc, 32'd0);

    // Capture via btnC and handshake.
    sw = 16'h003C;
    wait_cycles(20);
    btn[4] = 1'b1;
    wait_pulse(4, "c_pulse");
    check("c_valid_not_yet", 32'(cap_if.data_valid), 32'd0);
    step();
    check("c_pulse_one_cycle", 32'(press_pulse[4]), 32'd0);
    check("c_valid", 32'(cap_if.data_valid), 32'd1);
    check("c_data", 32'(cap_if.data_out), 32'h3C);
    btn[4] = 1'b0;
    changed = 1'b0;
    held_out = cap_if.data_out;
    for (int i = 0; i < 100; i++) begin
      step();
      if (cap_if.data_valid !== 1'b1 || cap_if.data_out !== held_out) changed = 1'b1;
    end
    check("hold_unchanged", 32'(changed), 32'd0);
    ack_byte("ack_clears_valid");
    step();
    check("ack_in_idle_valid", 32'(cap_if.data_valid), 32'd0);

    // C and U together: C wins, no overrun.
    sw = 16'h5A3C;
    wait_cycles(20);
    btn[4] = 1'b1;
    btn[3] = 1'b1;
    wait_pulse(4, "cu_pulse_c");
    check("cu_pulse_u", 32'(press_pulse[3]), 32'd1);
    step();
    check("cu_data", 32'(cap_if.data_out), 32'h3C);
    check("cu_no_overrun", 32'(cap_if.overrun), 32'd0);
    btn[4] = 1'b0;
    btn[3] = 1'b0;
    wait_cycles(20);
    ack_byte("cu_ack");

    // Overrun while holding a byte.
    btn[4] = 1'b1;
    wait_pulse(4, "ov_c_pulse");
    step();
    check("ov_first_data", 32'(cap_if.data_out), 32'h3C);
    btn[4] = 1'b0;
    wait_cycles(20);
    btn[3] = 1'b1;
    wait_pulse(3, "ov_u_pulse");
    step();
    check("ov_set", 32'(cap_if.overrun), 32'd1);
    check("ov_data_kept", 32'(cap_if.data_out), 32'h3C);
    check("ov_still_valid", 32'(cap_if.data_valid), 32'd1);
    btn[3] = 1'b0;
    wait_cycles(20);
    ack_byte("ov_ack");
    sw = 16'h813C;
    wait_cycles(20);
    btn[3] = 1'b1;
    wait_pulse(3, "u_pulse");
    step();
    check("u_data", 32'(cap_if.data_out), 32'h81);
    check("ov_sticky", 32'(cap_if.overrun), 32'd1);
    btn[3] = 1'b0;
    wait_cycles(20);

    // Reset mid-HOLD with D stable and R qualifying.
    btn[1] = 1'b1;
    wait_cycles(20);
    check("pre_rst_d_stable", 32'(buttons_stable), 32'h02);
    btn[2] = 1'b1;
    wait_cycles(6);
    #3;
    rst = 1'b1;
    #1;
    check("rst_async_outputs",
          {15'd0, cap_if.data_valid, cap_if.overrun, cap_if.data_out, buttons_stable, 2'b00},
          32'd0);
    check("rst_async_sw", 32'(sw_stable), 32'd0);
    step();
    step();
    rst = 1'b0;
    pulses = 0;
    acc = '0;
    for (int i = 0; i < 40; i++) begin
      step();
      pulses += int'(press_pulse[2]) + int'(press_pulse[1]);
      acc = acc | {31'd0, cap_if.data_valid};
    end
    check("requal_pulses", 32'(pulses), 32'd2);
    check("requal_no_capture", acc, 32'd0);
    check("requal_sw", 32'(sw_stable), 32'h813C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
